// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station slice.
// Also holds the CDB operand-capture rule, which alloc and wakeup both use.
package reservation_station_pkg;

    localparam int RS_SIZE  = 16;
    localparam int RS_IDX_W = 4;
    localparam int ROB_ID_W = 4;
    localparam int OPENUM_W = 6;

    typedef logic [RS_IDX_W-1:0] rs_idx_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [OPENUM_W-1:0] openum_t;
    typedef logic [31:0]         word_t;

    localparam rob_id_t ZERO_ROB  = '0;
    localparam word_t   ZERO_WORD = '0;

    typedef struct packed {
        logic    valid;
        rob_id_t rob_id;
        word_t   result;
    } cdb_t;

    typedef struct packed {
        rob_id_t q;
        word_t   v;
    } operand_t;

    // A waiting operand captures a CDB result on a tag match; Arith wins over LS.
    // Tag 0 means the value is already present, so it can never match.
    function automatic operand_t resolve_operand(operand_t op, cdb_t arith, cdb_t ls);
        operand_t res;
        res = op;
        if (op.q != ZERO_ROB) begin
            if (arith.valid && arith.rob_id == op.q) begin
                res.q = ZERO_ROB;
                res.v = arith.result;
            end else if (ls.valid && ls.rob_id == op.q) begin
                res.q = ZERO_ROB;
                res.v = ls.result;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatcher, CDB and ALU-issue signals of the reservation station.
// The slave modport is the station; master is the surrounding pipeline.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic    ena_from_dsp;
    openum_t openum_from_dsp;
    word_t   V1_from_dsp;
    word_t   V2_from_dsp;
    rob_id_t Q1_from_dsp;
    rob_id_t Q2_from_dsp;
    word_t   pc_from_dsp;
    word_t   imm_from_dsp;
    rob_id_t rob_id_from_dsp;

    logic    valid_from_Arith_unit_cdb;
    rob_id_t rob_id_from_Arith_unit_cdb;
    word_t   result_from_Arith_unit_cdb;
    logic    valid_from_LS_unit_cdb;
    rob_id_t rob_id_from_LS_unit_cdb;
    word_t   result_from_LS_unit_cdb;

    logic    full_to_if;
    logic    ena_to_alu;
    openum_t openum_to_alu;
    word_t   V1_to_alu;
    word_t   V2_to_alu;
    word_t   pc_to_alu;
    word_t   imm_to_alu;
    rob_id_t rob_id_to_alu;

    modport master (
        output ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp, Q1_from_dsp, Q2_from_dsp,
               pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
               valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, result_from_Arith_unit_cdb,
               valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, result_from_LS_unit_cdb,
        input  full_to_if, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu, pc_to_alu,
               imm_to_alu, rob_id_to_alu
    );

    modport slave (
        input  ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp, Q1_from_dsp, Q2_from_dsp,
               pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
               valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, result_from_Arith_unit_cdb,
               valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, result_from_LS_unit_cdb,
        output full_to_if, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu, pc_to_alu,
               imm_to_alu, rob_id_to_alu
    );

endinterface

// File: rtl/reservation_station_find_first.sv
// Combinational priority picker: index of the lowest set bit plus a found flag.
module rs_find_first #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scan downwards so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops, wakes operands from both CDBs,
// and issues the lowest-index ready op to the arithmetic unit each cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 misbranch_flag,
    reservation_station_if.slave bus
);

    logic [RS_SIZE-1:0] busy_q, busy_d, free_vec, ready_vec;

    openum_t openum_q [RS_SIZE];
    word_t   v1_q     [RS_SIZE];
    word_t   v2_q     [RS_SIZE];
    rob_id_t q1_q     [RS_SIZE];
    rob_id_t q2_q     [RS_SIZE];
    word_t   pc_q     [RS_SIZE];
    word_t   imm_q    [RS_SIZE];
    rob_id_t rob_q    [RS_SIZE];

    logic    ena_to_alu_q, full_q;
    openum_t openum_to_alu_q;
    word_t   v1_to_alu_q, v2_to_alu_q, pc_to_alu_q, imm_to_alu_q;
    rob_id_t rob_to_alu_q;

    cdb_t     arith_cdb, ls_cdb;
    operand_t new_op1, new_op2;
    operand_t [RS_SIZE-1:0] wake1, wake2;

    rs_idx_t free_idx, ready_idx;
    logic    free_found, ready_found, alloc_en, issue_en;

    assign arith_cdb = {bus.valid_from_Arith_unit_cdb, bus.rob_id_from_Arith_unit_cdb,
                        bus.result_from_Arith_unit_cdb};
    assign ls_cdb    = {bus.valid_from_LS_unit_cdb, bus.rob_id_from_LS_unit_cdb,
                        bus.result_from_LS_unit_cdb};

    // The dispatcher captured Q one cycle ago, so the current CDBs may already satisfy it.
    assign new_op1 = resolve_operand({bus.Q1_from_dsp, bus.V1_from_dsp}, arith_cdb, ls_cdb);
    assign new_op2 = resolve_operand({bus.Q2_from_dsp, bus.V2_from_dsp}, arith_cdb, ls_cdb);

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        assign wake1[gi]     = resolve_operand({q1_q[gi], v1_q[gi]}, arith_cdb, ls_cdb);
        assign wake2[gi]     = resolve_operand({q2_q[gi], v2_q[gi]}, arith_cdb, ls_cdb);
        assign ready_vec[gi] = busy_q[gi] && (q1_q[gi] == ZERO_ROB) && (q2_q[gi] == ZERO_ROB);
    end

    assign free_vec = ~busy_q;

    rs_find_first #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_pick (
        .vec_i(free_vec), .idx_o(free_idx), .found_o(free_found)
    );

    rs_find_first #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_pick (
        .vec_i(ready_vec), .idx_o(ready_idx), .found_o(ready_found)
    );

    assign alloc_en = bus.ena_from_dsp && free_found && !misbranch_flag;
    assign issue_en = ready_found && !misbranch_flag;

    always_comb begin
        busy_d = busy_q;
        if (misbranch_flag) begin
            busy_d = '0;
        end else begin
            if (issue_en) busy_d[ready_idx] = 1'b0;
            if (alloc_en) busy_d[free_idx]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q          <= '0;
            full_q          <= 1'b0;
            ena_to_alu_q    <= 1'b0;
            openum_to_alu_q <= '0;
            v1_to_alu_q     <= ZERO_WORD;
            v2_to_alu_q     <= ZERO_WORD;
            pc_to_alu_q     <= ZERO_WORD;
            imm_to_alu_q    <= ZERO_WORD;
            rob_to_alu_q    <= ZERO_ROB;
        end else if (rdy) begin
            busy_q       <= busy_d;
            // One slot of slack covers the op already in flight in the dispatcher.
            full_q       <= ($countones(busy_d) >= RS_SIZE - 1);
            ena_to_alu_q <= issue_en;
            if (issue_en) begin
                openum_to_alu_q <= openum_q[ready_idx];
                v1_to_alu_q     <= v1_q[ready_idx];
                v2_to_alu_q     <= v2_q[ready_idx];
                pc_to_alu_q     <= pc_q[ready_idx];
                imm_to_alu_q    <= imm_q[ready_idx];
                rob_to_alu_q    <= rob_q[ready_idx];
            end
        end
    end

    // Payload needs no reset: busy alone decides whether an entry's contents matter.
    always_ff @(posedge clk) begin
        if (rdy && !misbranch_flag) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc_en && free_idx == rs_idx_t'(i)) begin
                    openum_q[i] <= bus.openum_from_dsp;
                    v1_q[i]     <= new_op1.v;
                    q1_q[i]     <= new_op1.q;
                    v2_q[i]     <= new_op2.v;
                    q2_q[i]     <= new_op2.q;
                    pc_q[i]     <= bus.pc_from_dsp;
                    imm_q[i]    <= bus.imm_from_dsp;
                    rob_q[i]    <= bus.rob_id_from_dsp;
                end else if (busy_q[i]) begin
                    v1_q[i] <= wake1[i].v;
                    q1_q[i] <= wake1[i].q;
                    v2_q[i] <= wake2[i].v;
                    q2_q[i] <= wake2[i].q;
                end
            end
        end
    end

    assign bus.full_to_if    = full_q;
    assign bus.ena_to_alu    = ena_to_alu_q;
    assign bus.openum_to_alu = openum_to_alu_q;
    assign bus.V1_to_alu     = v1_to_alu_q;
    assign bus.V2_to_alu     = v2_to_alu_q;
    assign bus.pc_to_alu     = pc_to_alu_q;
    assign bus.imm_to_alu    = imm_to_alu_q;
    assign bus.rob_id_to_alu = rob_to_alu_q;

    // Dispatching into a completely full station loses the op.
    no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
        (rdy && !misbranch_flag && bus.ena_from_dsp) |-> free_found);

endmodule
